// File: rtl/demux_1_2_buf.sv
// demux_1_2_buf: buffered 1-to-2 demultiplexer. Each word from the producer
// is steered by sel into one of two show-ahead FIFOs, each draining to its
// own consumer through a valid/ready handshake.
// Optional delivery counters are enabled by defining DEMUX_COUNT_EN.
module demux_1_2_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Data_out_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic [WIDTH-1:0] Data_out_1,
    output logic             valid_1,
    input  logic             ready_1,
    output logic [7:0]       cnt_0,
    output logic [7:0]       cnt_1
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q   [2];
    logic [PW-1:0]    wr_d   [2];
    logic [PW-1:0]    rd_q   [2];
    logic [PW-1:0]    rd_d   [2];
    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [WIDTH-1:0] mem_d  [2][DEPTH];
    logic [WIDTH-1:0] dout_q [2];
    logic [WIDTH-1:0] dout_d [2];
    logic [1:0]       valid_q;
    logic [1:0]       valid_d;
    logic [1:0]       full_c;
    logic [1:0]       push_c;
    logic [1:0]       pop_c;
    logic [1:0]       rdy_c;

    // Full flags, input handshake and next FIFO state; the head word and
    // valid are precomputed so the outputs come straight from flops.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        full_c  = '0;
        push_c  = '0;
        pop_c   = '0;
        rdy_c   = {ready_1, ready_0};

        for (int n = 0; n < 2; n++) begin
            full_c[n] = (wr_q[n][PW-1] != rd_q[n][PW-1]) &&
                        (wr_q[n][AW-1:0] == rd_q[n][AW-1:0]);
        end

        // No full-bypass: a full FIFO blocks the producer even if it pops now.
        in_ready = !full_c[sel] && !flush && rst_n;

        for (int n = 0; n < 2; n++) begin
            push_c[n] = in_valid && in_ready && (sel == 1'(n));
            pop_c[n]  = valid_q[n] && rdy_c[n] && !flush;
            if (push_c[n]) begin
                mem_d[n][wr_q[n][AW-1:0]] = Data_in;
                wr_d[n] = wr_q[n] + PW'(1);
            end
            if (pop_c[n]) begin
                rd_d[n] = rd_q[n] + PW'(1);
            end
            if (flush) begin
                wr_d[n] = '0;
                rd_d[n] = '0;
            end
            valid_d[n] = (wr_d[n] != rd_d[n]);
            dout_d[n]  = mem_d[n][rd_d[n][AW-1:0]];
        end
    end

    // FIFO pointers, storage and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                wr_q[n]   <= '0;
                rd_q[n]   <= '0;
                dout_q[n] <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[n][i] <= '0;
                end
            end
            valid_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign Data_out_0 = dout_q[0];
    assign Data_out_1 = dout_q[1];
    assign valid_0    = valid_q[0];
    assign valid_1    = valid_q[1];

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];

    // Per-output delivery counters, wrapping at 8 bits, cleared by flush.
    always_comb begin
        cnt_d = cnt_q;
        for (int n = 0; n < 2; n++) begin
            if (flush) begin
                cnt_d[n] = '0;
            end else if (pop_c[n]) begin
                cnt_d[n] = cnt_q[n] + 8'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_0 = cnt_q[0];
    assign cnt_1 = cnt_q[1];
`else
    assign cnt_0 = '0;
    assign cnt_1 = '0;
`endif

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Testbench for demux_1_2_buf: directed scenarios plus random traffic, with
// a queue-based reference model of both output streams and their occupancy.
module tb_demux_1_2_buf;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] d0, d1, c0, c1;
    logic       valid_0, valid_1;
    logic       ready_0 = 1'b0;
    logic       ready_1 = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_c0 = 8'h00;
    logic [7:0] exp_c1 = 8'h00;
    logic       exp_rdy;

    always #5 clk = ~clk;

    demux_1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .Data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .Data_out_0(d0), .valid_0(valid_0), .ready_0(ready_0),
        .Data_out_1(d1), .valid_1(valid_1), .ready_1(ready_1),
        .cnt_0(c0), .cnt_1(c1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: check DUT against the model, then advance the model with
    // what the coming rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_c0 = 8'h00;
            exp_c1 = 8'h00;
            chk("rst_valid_0", int'(valid_0), 0);
            chk("rst_valid_1", int'(valid_1), 0);
            chk("rst_data_0", int'(d0), 0);
            chk("rst_data_1", int'(d1), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end else begin
            chk("valid_0", int'(valid_0), int'(exp_q0.size() != 0));
            chk("valid_1", int'(valid_1), int'(exp_q1.size() != 0));
            if (exp_q0.size() != 0) chk("data_0", int'(d0), int'(exp_q0[0]));
            if (exp_q1.size() != 0) chk("data_1", int'(d1), int'(exp_q1[0]));
            exp_rdy = !flush && ((sel ? exp_q1.size() : exp_q0.size()) < int'(DEPTH));
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            chk("cnt_0", int'(c0), int'(exp_c0));
            chk("cnt_1", int'(c1), int'(exp_c1));
            if (flush) begin
                exp_q0.delete();
                exp_q1.delete();
                exp_c0 = 8'h00;
                exp_c1 = 8'h00;
            end else begin
                if (exp_q0.size() != 0 && ready_0) begin
                    void'(exp_q0.pop_front());
`ifdef DEMUX_COUNT_EN
                    exp_c0 = exp_c0 + 8'd1;
`endif
                end
                if (exp_q1.size() != 0 && ready_1) begin
                    void'(exp_q1.pop_front());
`ifdef DEMUX_COUNT_EN
                    exp_c1 = exp_c1 + 8'd1;
`endif
                end
                if (in_valid && exp_rdy) begin
                    if (sel) exp_q1.push_back(data_in);
                    else     exp_q0.push_back(data_in);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1, input logic fl);
        @(posedge clk);
        #1;
        in_valid = iv;
        sel      = s;
        data_in  = d;
        ready_0  = r0;
        ready_1  = r1;
        flush    = fl;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("async_valid_0", int'(valid_0), 0);
        chk("async_valid_1", int'(valid_1), 0);
        chk("async_data_0", int'(d0), 0);
        chk("async_data_1", int'(d1), 0);
        chk("async_cnt_0", int'(c0), 0);
        chk("async_cnt_1", int'(c1), 0);
        chk("async_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Steering
        drive(1, 0, 8'hA5, 1, 1, 0);
        drive(1, 1, 8'h3C, 1, 1, 0);
        drive(0, 0, 8'h00, 1, 1, 0);
        drive(0, 0, 8'h00, 1, 1, 0);

        // Backpressure / full, then drain in order
        drive(1, 0, 8'h11, 0, 0, 0);
        drive(1, 0, 8'h22, 0, 0, 0);
        drive(1, 0, 8'h33, 0, 0, 0);
        drive(1, 0, 8'h33, 0, 0, 0);
        drive(1, 0, 8'h33, 1, 0, 0);
        drive(1, 0, 8'h33, 1, 0, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        repeat (3) drive(0, 0, 8'h00, 1, 0, 0);

        // Independence: output 0 full and stalled, output 1 still flows
        drive(1, 0, 8'h11, 0, 1, 0);
        drive(1, 0, 8'h22, 0, 1, 0);
        drive(1, 0, 8'h44, 0, 1, 0);
        drive(1, 1, 8'h77, 0, 1, 0);
        drive(0, 1, 8'h00, 0, 1, 0);
        drive(0, 1, 8'h00, 0, 1, 0);

        // Flush with two words per output and a word offered on the flush cycle
        drive(0, 0, 8'h00, 0, 0, 1);
        drive(1, 0, 8'h01, 0, 0, 0);
        drive(1, 0, 8'h02, 0, 0, 0);
        drive(1, 1, 8'h03, 0, 0, 0);
        drive(1, 1, 8'h04, 0, 0, 0);
        drive(1, 0, 8'h99, 0, 0, 1);
        drive(0, 0, 8'h00, 1, 1, 0);
        drive(0, 0, 8'h00, 1, 1, 0);

        // Reset mid-stream with buffered words
        drive(1, 0, 8'h5A, 0, 0, 0);
        drive(1, 1, 8'h6B, 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        do_reset();
        repeat (3) drive(0, 0, 8'h00, 1, 1, 0);

        // Counter: 257 deliveries on output 1 only
        drive(0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 257; i++) drive(1, 1, 8'($urandom), 1, 1, 0);
        repeat (3) drive(0, 1, 8'h00, 1, 1, 0);
        @(negedge clk);
`ifdef DEMUX_COUNT_EN
        chk("cnt_1_wrap", int'(c1), 1);
`else
        chk("cnt_1_wrap", int'(c1), 0);
`endif
        chk("cnt_0_idle", int'(c0), 0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                      1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 63) == 0));
            end
        end
        drive(0, 0, 8'h00, 1, 1, 0);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_1_2_buf.md
Name: demux_1_2_buf

Overview:
- Buffered 1-to-2 demultiplexer for the 8-bit datapath; the write-side counterpart of the 2:1 data mux.
- Steers one producer word stream to one of two consumers, selected per word by sel.
- Each destination has its own small show-ahead FIFO with valid/ready handshake, so one stalled consumer never corrupts the other's data ordering.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both FIFOs.
- Data_in  input  WIDTH  word from producer.
- sel  input  1  destination of Data_in: 0 -> output 0, 1 -> output 1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word toward the current sel.
- Data_out_0  output  WIDTH  head word of FIFO 0.
- valid_0  output  1  FIFO 0 not empty.
- ready_0  input  1  consumer 0 takes the head word.
- Data_out_1  output  WIDTH  head word of FIFO 1.
- valid_1  output  1  FIFO 1 not empty.
- ready_1  input  1  consumer 1 takes the head word.
- cnt_0  output  8  words delivered on output 0 (see Optional Feature).
- cnt_1  output  8  words delivered on output 1 (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pointers and storage cleared.
  - valid_0/1 = 0, Data_out_0/1 = 0, cnt_0/1 = 0.
  - in_ready = 0 while rst_n is low.
- Release from reset is synchronous to the next rising edge.
- Reset mid-transfer discards all buffered words; none are delivered after release.
- Per-FIFO state: write pointer and read pointer, each log2(DEPTH)+1 bits.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo 2*DEPTH.
- in_ready = !full[sel] && !flush && rst_n; combinational from sel and state only, never from ready_0/1.
- Push: in_valid && in_ready at an edge writes Data_in into FIFO[sel].
  - sel is sampled only at the accepting edge.
  - A word accepted at edge k appears at the FIFO head (valid_n = 1) after edge k; latency is 1 cycle.
- Pop: valid_n && ready_n at an edge advances FIFO n's read pointer.
  - ready_n while valid_n = 0 is ignored.
- Data_out_n is the head entry (show-ahead) and is held stable while valid_n && !ready_n.
- Simultaneous push and pop on the same FIFO: allowed when not full; occupancy unchanged.
- Full FIFO: in_ready = 0 for that sel even if the consumer pops in the same cycle (no full-bypass path).
  - The next cycle in_ready rises.
- Producer is allowed to change sel while in_valid is high and in_ready is low; in_ready re-evaluates for the new sel.
- Per-output ordering is preserved; there is no ordering relation between outputs.
- flush (synchronous, priority over push and pop):
  - Clears both FIFOs' pointers and cnt_0/1.
  - valid_0/1 = 0 after the edge.
  - No word is accepted or delivered on the flush cycle.
- Both outputs operate fully independently; simultaneous pops on both outputs in one cycle are legal.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - cnt_n increments by 1 on each pop (valid_n && ready_n) of output n.
  - 8-bit, wraps 255 -> 0.
  - Cleared by reset and by flush.
- Not defined:
  - cnt_0 and cnt_1 are tied to 0.
  - No counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset/idle:
  - Assert rst_n = 0 mid-stream with words buffered -> valid_0/1 = 0, Data_out_0/1 = 0x00, cnt = 0 immediately.
  - After release, no stale words appear.
- Steering: push 0xA5 (sel=0), 0x3C (sel=1) with ready_0/1 = 1 -> 0xA5 on output 0 and 0x3C on output 1, each valid exactly 1 cycle after its accept edge.
- Backpressure/full (DEPTH=2):
  - ready_0 = 0; push 0x11, 0x22, 0x33 to sel=0 -> in_ready = 0 after the second accept.
  - Data_out_0 holds 0x11.
  - Raise ready_0 -> 0x11, 0x22, 0x33 delivered in order; 0x33 is accepted the cycle after the first pop.
- Independence: output 0 full and stalled, sel=1 push 0x77 -> in_ready = 1, 0x77 delivered on output 1 while output 0 stays 0x11.
- Flush: 2 words buffered per output; flush = 1 with in_valid = 1 -> next cycle valid_0/1 = 0, input word not stored, cnt = 0.
- Counter (DEMUX_COUNT_EN): deliver 257 words on output 1 -> cnt_1 = 1, cnt_0 = 0.
  - Without the macro, both counters read 0 throughout.
